// File: rtl/ccff_loader_pkg.sv
// ccff_loader_pkg: loader state type and CRC-16-CCITT helpers shared by the chain loader.
package ccff_loader_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, RELEASE, DONE} state_t;
    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    function automatic logic [15:0] crc_next(input logic [15:0] crc, input logic din);
        return {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? CRC_POLY : 16'h0000);
    endfunction
endpackage

// File: rtl/ccff_crc16.sv
// ccff_crc16: bit-serial CRC-16-CCITT register; clr restarts it at CRC_INIT for a new load.
module ccff_crc16
    import ccff_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);
    always_ff @(posedge clk or posedge rst)
        if (rst) crc <= CRC_INIT;
        else if (clr) crc <= CRC_INIT;
        else if (en) crc <= crc_next(crc, din);
endmodule

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serialises stream words LSB-first into the ccff chain head and holds I/O isolated until done.
// Define CCFF_CRC_EN to check a CRC-16 of the shifted stream against exp_crc before releasing isolation.
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int LEN_W  = 20
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              abort,
    input  logic [LEN_W-1:0]  chain_len,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic [15:0]       exp_crc,
    output logic              ccff_head,
    output logic              ccff_shift,
    output logic              isol_n,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       cfg_crc
);
    localparam int BL_W = $clog2(WORD_W + 1);
    state_t            state;
    logic [WORD_W-1:0] sreg;
    logic [BL_W-1:0]   bits_left;
    logic [LEN_W-1:0]  len, bit_cnt;
    logic              in_load, last_shift, accept, launch, crc_bad;
    // The final shift withholds cfg_ready so no word is taken only to be discarded.
    always_comb begin
        in_load    = state == LOAD && !abort;
        ccff_shift = in_load && bits_left != '0;
        ccff_head  = sreg[0];
        last_shift = ccff_shift && bit_cnt + LEN_W'(1) == len;
        cfg_ready  = in_load && (bits_left == '0 || (bits_left == BL_W'(1) && ccff_shift && !last_shift));
        accept     = cfg_valid && cfg_ready;
        launch     = start && (state == IDLE || state == DONE);
    end
`ifdef CCFF_CRC_EN
    ccff_crc16 u_crc (
        .clk (prog_clk),
        .rst (prog_reset),
        .clr (launch),
        .en  (ccff_shift),
        .din (ccff_head),
        .crc (cfg_crc)
    );
    assign crc_bad = cfg_crc != exp_crc;
`else
    logic unused_exp_crc;
    assign unused_exp_crc = ^exp_crc;
    assign cfg_crc = '0;
    assign crc_bad = 1'b0;
`endif
    always_ff @(posedge prog_clk or posedge prog_reset)
        if (prog_reset) begin
            state     <= IDLE;
            sreg      <= '0;
            bits_left <= '0;
            len       <= '0;
            bit_cnt   <= '0;
            isol_n    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    len       <= chain_len;
                    bit_cnt   <= '0;
                    bits_left <= '0;
                    done      <= 1'b0;
                    err       <= 1'b0;
                    isol_n    <= 1'b0;
                    busy      <= 1'b1;
                    state     <= chain_len == '0 ? RELEASE : LOAD;
                end
                LOAD: if (abort) begin
                    err   <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end else begin
                    if (ccff_shift) bit_cnt <= bit_cnt + LEN_W'(1);
                    if (last_shift) begin
                        bits_left <= '0;
                        state     <= RELEASE;
                    end else if (accept) begin
                        sreg      <= cfg_data;
                        bits_left <= BL_W'(WORD_W);
                    end else if (ccff_shift) begin
                        sreg      <= sreg >> 1;
                        bits_left <= bits_left - BL_W'(1);
                    end
                end
                RELEASE: begin
                    state  <= DONE;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    err    <= crc_bad;
                    isol_n <= !crc_bad;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: directed and randomized loads checked against a bit-queue model of the chain stream.
module tb_ccff_chain_loader;
    localparam int W = 32;
    localparam int L = 20;
    logic prog_clk = 1'b0;
    logic prog_reset, start, abort, cfg_valid, cfg_ready, ccff_head, ccff_shift, isol_n, busy, done, err;
    logic [L-1:0]  chain_len;
    logic [W-1:0]  cfg_data;
    logic [15:0]   exp_crc, cfg_crc;
    int tests = 0;
    int fails = 0;
`ifdef CCFF_CRC_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    always #5 prog_clk = ~prog_clk;

    ccff_chain_loader #(.WORD_W(W), .LEN_W(L)) dut (
        .prog_clk   (prog_clk),
        .prog_reset (prog_reset),
        .start      (start),
        .abort      (abort),
        .chain_len  (chain_len),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_data   (cfg_data),
        .exp_crc    (exp_crc),
        .ccff_head  (ccff_head),
        .ccff_shift (ccff_shift),
        .isol_n     (isol_n),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cfg_crc    (cfg_crc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: the chain must see the accepted words' bits LSB-first, exactly len of them.
    task automatic run_load(input int len, input int pct, input int gap, input logic [31:0] word0,
                            input int abort_at, input logic crc_bad);
        bit q[$];
        int shifted = 0, acc = 0, dacc = 0, gapc = 0, cyc = 0, first = -1, last = -1;
        logic es, er, aborted = 1'b0;
        logic [15:0] crc = 16'hFFFF;
        chain_len = L'(len);
        start = 1'b1;
        cfg_valid = 1'b0;
        @(posedge prog_clk);
        #1 start = 1'b0;
        chain_len = 5;
        cfg_valid = ($urandom_range(99) < pct);
        cfg_data = word0;
        while (shifted < len && !aborted && cyc < 3000) begin
            @(negedge prog_clk);
            es = q.size() > 0 && !abort;
            er = !abort && (q.size() - int'(es) == 0) && (shifted + int'(es) < len);
            chk("load_shift", ccff_shift, es);
            chk("load_ready", cfg_ready, er);
            chk("load_busy", busy, 1'b1);
            chk("load_isol", isol_n, 1'b0);
            if (es) chk($sformatf("head_bit%0d", shifted), ccff_head, q[0]);
            if (cfg_valid && cfg_ready) dacc++;
            if (abort) aborted = 1'b1;
            @(posedge prog_clk);
            if (es) begin
                crc = {crc[14:0], 1'b0} ^ ((crc[15] ^ q[0]) ? 16'h1021 : 16'h0000);
                void'(q.pop_front());
                shifted++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            if (cfg_valid && er) begin
                acc++;
                for (int i = 0; i < W; i++) q.push_back(cfg_data[i]);
                if (acc == 1) gapc = gap;
            end
            cyc++;
            #1;
            abort = (shifted == abort_at) && !aborted;
            start = (shifted == 3) && len > 8;
            if (gapc > 0) begin
                gapc--;
                cfg_valid = 1'b0;
            end else cfg_valid = ($urandom_range(99) < pct);
            cfg_data = (acc == 0) ? word0 : $urandom;
        end
        if (cyc >= 3000) chk("load_timeout", 1'b1, 1'b0);
        start = 1'b0;
        abort = 1'b0;
        cfg_valid = 1'b0;
        exp_crc = crc ^ {15'b0, crc_bad};
        @(negedge prog_clk);
        if (aborted) begin
            chk("abort_err", err, 1'b1);
            chk("abort_busy", busy, 1'b0);
            chk("abort_isol", isol_n, 1'b0);
            chk("abort_done", done, 1'b0);
            chk("abort_shift", ccff_shift, 1'b0);
            chk("abort_shifts", shifted, abort_at);
            return;
        end
        chk("rel_busy", busy, 1'b1);
        chk("rel_shift", ccff_shift, 1'b0);
        chk("rel_ready", cfg_ready, 1'b0);
        chk("rel_isol", isol_n, 1'b0);
        chk("rel_done", done, 1'b0);
        @(negedge prog_clk);
        chk("done_done", done, 1'b1);
        chk("done_busy", busy, 1'b0);
        chk("done_err", err, CRC_ON && crc_bad);
        chk("done_isol", isol_n, !(CRC_ON && crc_bad));
        chk("done_crc", cfg_crc, CRC_ON ? crc : 16'h0);
        chk("words_model", acc, (len + W - 1) / W);
        chk("words_dut", dacc, (len + W - 1) / W);
        if (pct == 100 && gap == 0) chk("no_bubble_span", last - first + 1, len);
    endtask

    initial begin
        prog_reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        chain_len = '0;
        cfg_valid = 1'b0;
        cfg_data = '0;
        exp_crc = '0;
        #12;
        chk("rst_head", ccff_head, 1'b0);
        chk("rst_shift", ccff_shift, 1'b0);
        chk("rst_ready", cfg_ready, 1'b0);
        chk("rst_isol", isol_n, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_crc", cfg_crc, CRC_ON ? 16'hFFFF : 16'h0);
        @(posedge prog_clk);
        #1 prog_reset = 1'b0;

        run_load(4, 100, 0, 32'h0000_000B, -1, 1'b0);

        // Zero-length chain goes straight through RELEASE.
        @(posedge prog_clk);
        #1 chain_len = '0;
        start = 1'b1;
        exp_crc = 16'hFFFF;
        @(posedge prog_clk);
        #1 start = 1'b0;
        @(negedge prog_clk);
        chk("zero_busy", busy, 1'b1);
        chk("zero_isol", isol_n, 1'b0);
        chk("zero_shift", ccff_shift, 1'b0);
        @(negedge prog_clk);
        chk("zero_done", done, 1'b1);
        chk("zero_isol_rel", isol_n, 1'b1);
        chk("zero_err", err, 1'b0);

        run_load(70, 100, 0, $urandom, -1, 1'b0);
        run_load(40, 100, 5, $urandom, -1, 1'b0);
        for (int n = 0; n < 6; n++)
            run_load($urandom_range(1, 120), $urandom_range(30, 100), 0, $urandom, -1, 1'b0);
        run_load(64, 100, 0, $urandom, 10, 1'b0);
        run_load(64, 70, 0, $urandom, -1, 1'b0);

        // Asynchronous reset between edges mid-load.
        chain_len = 64;
        start = 1'b1;
        @(posedge prog_clk);
        #1 start = 1'b0;
        cfg_valid = 1'b1;
        cfg_data = $urandom;
        repeat (5) @(posedge prog_clk);
        #2 prog_reset = 1'b1;
        #1;
        chk("arst_shift", ccff_shift, 1'b0);
        chk("arst_ready", cfg_ready, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_isol", isol_n, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_err", err, 1'b0);
        cfg_valid = 1'b0;
        chain_len = 8;
        start = 1'b1;
        repeat (2) @(posedge prog_clk);
        #1 start = 1'b0;
        prog_reset = 1'b0;
        @(negedge prog_clk);
        chk("arst_start_busy", busy, 1'b0);
        chk("arst_start_shift", ccff_shift, 1'b0);

        run_load(32, 100, 0, 32'h1234_5678, -1, 1'b0);
        run_load(32, 100, 0, 32'h1234_5678, -1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
